// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: state encoding, frame sync byte
// and instruction width.
package program_loader_pkg;

   localparam int          INS_W     = 12;
   localparam logic [7:0]  SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_COUNT,
      ST_HI,
      ST_LO,
      ST_CHECK,
      ST_DONE,
      ST_ERR
   } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, arm pulse and program-memory load port of the loader.
interface program_loader_if #(parameter int ADDR_W = 8) ();
   import program_loader_pkg::*;

   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              load_we;
   logic [ADDR_W-1:0] load_addr;
   logic [INS_W-1:0]  load_ins;
   logic              load_done;
   logic              load_err;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, load_we, load_addr, load_ins, load_done, load_err
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, load_we, load_addr, load_ins, load_done, load_err
   );

endinterface

// File: rtl/program_loader.sv
// Framed byte stream (A5, N, N x {hi,lo} [, xor]) to program memory writes.
// Trailing checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int DEPTH  = 10,
   parameter int ADDR_W = 8
) (
   input  logic            CLK,
   input  logic            RST,
   program_loader_if.slave bus
);

   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   state_e             state, state_d;
   logic [7:0]         cnt, cnt_d;
   logic [7:0]         idx, idx_d;
   logic [3:0]         nib, nib_d;
   logic               we_d, done_d, err_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [INS_W-1:0]   ins_d;
   logic               acc;
   logic [7:0]         idx_inc;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]         csum, csum_d;
`endif

   assign bus.in_ready = (state == ST_SYNC) || (state == ST_COUNT) || (state == ST_HI) ||
                         (state == ST_LO)   || (state == ST_CHECK);
   assign acc     = bus.in_valid && bus.in_ready;
   assign idx_inc = idx + 8'd1;

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      nib_d   = nib;
      we_d    = 1'b0;
      addr_d  = bus.load_addr;
      ins_d   = bus.load_ins;
      done_d  = bus.load_done;
      err_d   = bus.load_err;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d  = csum;
`endif
      // start wins over a byte accepted in the same cycle
      if (bus.start) begin
         state_d = ST_SYNC;
         idx_d   = 8'd0;
         done_d  = 1'b0;
         err_d   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_d  = 8'd0;
`endif
      end else if (acc) begin
         case (state)
            ST_SYNC: if (bus.in_data == SYNC_BYTE) state_d = ST_COUNT;
            ST_COUNT: begin
               if (bus.in_data == 8'd0 || bus.in_data > DEPTH_B) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else begin
                  cnt_d   = bus.in_data;
                  idx_d   = 8'd0;
                  state_d = ST_HI;
               end
            end
            ST_HI: begin
               nib_d   = bus.in_data[3:0];
               state_d = ST_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum_d  = csum ^ bus.in_data;
`endif
            end
            ST_LO: begin
               we_d    = 1'b1;
               addr_d  = ADDR_W'(idx);
               ins_d   = {nib, bus.in_data};
               idx_d   = idx_inc;
               state_d = ST_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum_d  = csum ^ bus.in_data;
               if (idx_inc == cnt) state_d = ST_CHECK;
`else
               if (idx_inc == cnt) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
`endif
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (bus.in_data == csum) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state         <= ST_IDLE;
         cnt           <= 8'd0;
         idx           <= 8'd0;
         nib           <= 4'd0;
         bus.load_we   <= 1'b0;
         bus.load_addr <= '0;
         bus.load_ins  <= '0;
         bus.load_done <= 1'b0;
         bus.load_err  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum          <= 8'd0;
`endif
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         idx           <= idx_d;
         nib           <= nib_d;
         bus.load_we   <= we_d;
         bus.load_addr <= addr_d;
         bus.load_ins  <= ins_d;
         bus.load_done <= done_d;
         bus.load_err  <= err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum          <= csum_d;
`endif
      end
   end

endmodule
